// File: rtl/mux16_arbiter_pkg.sv
// Shared constants and types for the 16-way round-robin mux arbiter.
package mux_arb_pkg;
  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/mux16_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface mux16_arbiter_if;
  import mux_arb_pkg::*;
  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             timeout;

  modport master (output req, done, input gnt, sel, busy, timeout);
  modport slave  (input req, done, output gnt, sel, busy, timeout);
endinterface

// File: rtl/mux16_arbiter_rr_pick16.sv
// Combinational round-robin picker: first unmasked request at or after ptr, wrapping.
module rr_pick16
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic [N_REQ-1:0] excl_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);
  logic [N_REQ-1:0] m;
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  assign m = req_i & ~excl_i;

  // rot[i] is the request sitting i positions after ptr
  for (genvar i = 0; i < N_REQ; i++) begin : g_rot
    logic [SEL_W-1:0] pos;
    assign pos    = ptr_i + SEL_W'(i);
    assign rot[i] = m[pos];
  end

  always_comb begin
    off = '0;
    for (int i = N_REQ-1; i >= 0; i--)
      if (rot[i]) off = SEL_W'(i);
  end

  assign found_o = |rot;
  assign idx_o   = ptr_i + off;
endmodule

// File: rtl/mux16_arbiter.sv
// Round-robin owner arbiter for a shared 16:1 mux with a bounded hold time.
module mux16_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input logic            clk,
  input logic            reset,
  mux16_arbiter_if.slave bus
);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [SEL_W-1:0] sel_q, ptr_q;
  logic             busy_q, timeout_q;
  logic [7:0]       cnt_q;

  logic             in_grant, expire, owner_req, rel;
  logic [SEL_W-1:0] pick_ptr, idx;
  logic [N_REQ-1:0] pick_excl;
  logic             found;

  assign in_grant  = (state_q == GRANT);
  assign expire    = (cnt_q == HOLD_LAST);
  assign owner_req = bus.req[sel_q];
  assign rel       = in_grant & (bus.done | ~owner_req | expire);

  // On release the search starts just past the owner, which is masked out
  assign pick_ptr  = in_grant ? sel_q + SEL_W'(1) : ptr_q;
  assign pick_excl = in_grant ? onehot(sel_q) : '0;

  rr_pick16 u_pick (
    .req_i  (bus.req),
    .ptr_i  (pick_ptr),
    .excl_i (pick_excl),
    .found_o(found),
    .idx_o  (idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= GRANT;
            gnt_q   <= onehot(idx);
            sel_q   <= idx;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr_q     <= sel_q + SEL_W'(1);
            // Only a pure expiry counts as a timeout
            timeout_q <= expire & ~bus.done & owner_req;
            cnt_q     <= '0;
            if (found) begin
              gnt_q <= onehot(idx);
              sel_q <= idx;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
endmodule

// File: doc/mux16_arbiter.md
MUX16_ARBITER -- requirements
Module: mux16_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive cycles one requester may own the shared 16:1 mux (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
REQ-004 req  input  16  request vector; req[i]=1 means requester i wants the shared mux.
REQ-005 done  input  1  end-of-transfer from the current owner; sampled only in GRANT.
REQ-006 gnt  output  16  one-hot grant, all-zero when idle; registered.
REQ-007 sel  output  4  binary index of owner, drives mux16_1-style sel; registered.
REQ-008 busy  output  1  1 while in GRANT; registered.
REQ-009 timeout  output  1  one-cycle pulse when ownership ends by MAX_HOLD expiry; registered.

Function
REQ-010 Two states: IDLE (no owner), GRANT (owner = sel).
REQ-011 Round-robin pointer ptr (4 bits): search starts at ptr, ascending, wraps 15->0.
REQ-012 IDLE, any req=1: next edge enters GRANT, owner = first requester found from ptr; gnt/sel/busy valid 1 cycle after req seen.
REQ-013 IDLE, req=0: stay IDLE; gnt=0, busy=0, sel holds last value.
REQ-014 GRANT: hold counter cnt increments each cycle from 0 at grant edge.
REQ-015 Release conditions in GRANT: done=1, or req[sel]=0, or cnt=MAX_HOLD-1.
REQ-016 On release: ptr <= sel+1 (mod 16); current owner excluded from the same-edge arbitration.
REQ-017 Release with another req pending: next edge grants it directly (back-to-back, no idle bubble), cnt restarts at 0.
REQ-018 Release with no other req: next edge enters IDLE; lone re-requesting owner is re-granted one cycle later.
REQ-019 timeout=1 for exactly the cycle following a release caused only by cnt expiry; done=1 or req[sel]=0 on the expiry cycle suppresses timeout.
REQ-020 gnt always one-hot or zero; gnt[sel]=1 whenever busy=1; never two owners in any cycle.
REQ-021 req changes for non-owners during GRANT have no effect until release.
REQ-022 done in IDLE ignored.

Reset
REQ-023 While reset=0: state=IDLE, gnt=0, sel=0, busy=0, timeout=0, ptr=0, cnt=0.
REQ-024 Reset asserted mid-GRANT drops grant asynchronously; first arbitration after release of reset starts from ptr=0.

Structure
REQ-025 Package mux_arb_pkg holds N_REQ=16, SEL_W=4, state enum {IDLE, GRANT}.
REQ-026 One sub-module rr_pick16: combinational, inputs req[15:0], ptr[3:0], exclude mask; outputs found, idx[3:0].
REQ-027 All outputs driven from flops; no combinational path req->gnt.

Verification
REQ-028 Reset then req=16'h0001 -> one cycle later gnt=16'h0001, sel=0, busy=1.
REQ-029 req=16'h8001 constant, done pulsed each 3rd owned cycle -> grants alternate 0,15,0,15; ptr wrap 15->0 verified.
REQ-030 req=16'h0010 held, done=0, MAX_HOLD=8 -> owner 4 released after 8 cycles, timeout pulses 1 cycle, IDLE 1 cycle, re-granted.
REQ-031 req=16'h0024, owner 2 issues done same cycle as cnt expiry -> timeout stays 0, gnt moves to 16'h0020 next cycle.
REQ-032 reset=0 asserted mid-GRANT with sel=9 -> gnt=0, busy=0, sel=0 without clock edge; after release req=16'hFFFF -> gnt=16'h0001.
REQ-033 Random req/done for 10000 cycles -> assertions: gnt one-hot-or-zero, gnt[sel]=busy, no owner exceeds MAX_HOLD cycles, every persistent requester granted within 16*MAX_HOLD+16 cycles.
